// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial add/subtract unit: op encoding,
// controller state encoding and the index-width helper.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Ceiling log2; callers clamp the result to at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// DIGIT-wide ripple of full adders; the only adder in the unit, shared by
// the complement-add pass and the re-complement pass.
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  // Ripple the carry bit by bit through the digit.
  always_comb begin : ripple
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract unit with sign-magnitude subtract result.
// Pass 1 computes a + b (or a + ~b + 1); a negative subtract result is
// re-complemented in pass 2. Valid/ready handshake on both sides.
// Optional build macro: SERIAL_ADDSUB_SAT_EN (add overflow saturates out_mag).
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_neg,
  output logic             out_cout,
  output logic             busy
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (clog2(N) > 0) ? clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_addsub: WIDTH must be a multiple of DIGIT");
  end

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic               op;
  logic [WIDTH-1:0]   a_r, b_r, w;
  logic               neg_r, cout_r;

  int                 sh;
  logic [DIGIT-1:0]   dig_a, dig_b, dig_s;
  logic               dig_cout;
  logic [WIDTH-1:0]   w_merge;
  logic               last;

  assign last      = (idx == LAST);
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_mag   = w;
  assign out_neg   = neg_r;
  assign out_cout  = cout_r;

  // Route the current digit of the operands (pass 1) or of the stored
  // result (pass 2) into the shared digit adder.
  always_comb begin
    sh    = int'(idx) * DIGIT;
    dig_a = DIGIT'(a_r >> sh);
    dig_b = DIGIT'(b_r >> sh);
    if (state == PASS2) begin
      dig_a = ~DIGIT'(w >> sh);
      dig_b = '0;
    end else if (op == OP_SUB) begin
      dig_b = ~dig_b;
    end
    w_merge = (w & ~(WIDTH'({DIGIT{1'b1}}) << sh)) | (WIDTH'(dig_s) << sh);
  end

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry),
    .s    (dig_s),
    .cout (dig_cout)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: pass 2 only runs for a subtract that borrowed in pass 1.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (in_valid) state_next = PASS1;
      PASS1: if (last) state_next = (op == OP_ADD || dig_cout) ? DONE : PASS2;
      PASS2: if (last) state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, digit-by-digit result update and flag resolution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      op     <= OP_ADD;
      a_r    <= '0;
      b_r    <= '0;
      w      <= '0;
      neg_r  <= 1'b0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r    <= in_a;
          b_r    <= in_b;
          op     <= in_op;
          carry  <= in_op;
          idx    <= '0;
          neg_r  <= 1'b0;
          cout_r <= 1'b0;
        end
        PASS1: begin
          w     <= w_merge;
          carry <= dig_cout;
          idx   <= last ? '0 : idx + IDX_W'(1);
          if (last) begin
            if (op == OP_ADD) begin
              cout_r <= dig_cout;
              neg_r  <= 1'b0;
`ifdef SERIAL_ADDSUB_SAT_EN
              if (dig_cout) w <= '1;
`endif
            end else if (dig_cout) begin
              cout_r <= 1'b1;
              neg_r  <= 1'b0;
            end else begin
              // Borrow: result is negative, re-complement in pass 2.
              cout_r <= 1'b0;
              neg_r  <= 1'b1;
              carry  <= 1'b1;
            end
          end
        end
        PASS2: begin
          w     <= w_merge;
          carry <= dig_cout;
          idx   <= last ? '0 : idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
